// File: rtl/otter_crypto_pkg.sv
// Shared constants, encodings and helpers for the ENCRY iterative cipher unit.
package otter_crypto_pkg;

  localparam logic [6:0]  OP_ENCRY    = 7'b1011011;
  localparam logic [2:0]  CRY_ENC     = 3'b000;
  localparam logic [2:0]  CRY_DEC     = 3'b001;
  localparam int unsigned DEF_ROT_AMT = 5;
  localparam logic [31:0] DEF_RC      = 32'h9E3779B9;

  typedef enum logic {IDLE, RUN} cry_state_t;
  typedef enum logic {MODE_ENC, MODE_DEC} cry_mode_t;

  function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] n);
    logic [63:0] t;
    t = {v, v} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] n);
    logic [63:0] t;
    t = {v, v} >> n;
    return t[31:0];
  endfunction

endpackage

// File: rtl/otter_crypto_if.sv
// Control-unit facing bus of the crypto unit; names match the CPU integration.
interface otter_crypto_if;
  logic        CRY_EN;
  logic [1:0]  CRY_COUNT;
  logic [2:0]  CRY_FUNC3;
  logic [31:0] CRY_RS1;
  logic [31:0] CRY_RS2;
  logic [31:0] CRY_RESULT;
  logic        CRY_VALID;
  logic        CRY_BUSY;
  logic        CRY_ERR;

  modport master (
    output CRY_EN, CRY_COUNT, CRY_FUNC3, CRY_RS1, CRY_RS2,
    input  CRY_RESULT, CRY_VALID, CRY_BUSY, CRY_ERR
  );

  modport slave (
    input  CRY_EN, CRY_COUNT, CRY_FUNC3, CRY_RS1, CRY_RS2,
    output CRY_RESULT, CRY_VALID, CRY_BUSY, CRY_ERR
  );
endinterface

// File: rtl/otter_crypto_round.sv
// One cipher round (key schedule + encrypt/decrypt form), purely combinational.
module otter_crypto_round
  import otter_crypto_pkg::*;
#(
  parameter int unsigned ROT_AMT = DEF_ROT_AMT,
  parameter logic [31:0] RC      = DEF_RC
) (
  input  logic [31:0] x,
  input  logic [31:0] key,
  input  logic [1:0]  r,
  input  cry_mode_t   mode,
  output logic [31:0] y
);

  localparam logic [4:0] ROT = 5'(ROT_AMT);

  logic [1:0]  j;
  logic [31:0] mul;
  logic [31:0] k;

  // Decrypt walks the key schedule backwards so it undoes encrypt round by round.
  always_comb begin
    j   = (mode == MODE_DEC) ? 2'd3 - r : r;
    mul = 32'(j) + 32'd1;
    k   = rotl32(key, {j, 3'b000}) ^ (RC * mul);
    if (mode == MODE_DEC)
      y = rotr32(x - k, ROT) ^ k;
    else
      y = rotl32(x ^ k, ROT) + k;
  end

endmodule

// File: rtl/otter_crypto_unit.sv
// Iterative 4-round ENCRY datapath driven by the control unit's crypto_count;
// result and VALID are combinational in the count==3 cycle.
module otter_crypto_unit
  import otter_crypto_pkg::*;
#(
  parameter int unsigned ROT_AMT = DEF_ROT_AMT,
  parameter logic [31:0] RC      = DEF_RC
) (
  input  logic           CRY_CLK,
  input  logic           CRY_RESET,
  otter_crypto_if.slave  bus
);

  cry_state_t  state;
  cry_mode_t   mode;
  logic [1:0]  rnd;
  logic [31:0] dreg;

  logic        legal;
  cry_mode_t   in_mode;
  logic [31:0] rx;
  logic [1:0]  rr;
  cry_mode_t   rmode;
  logic [31:0] ry;
  logic        step_ok;
  logic        valid;
  logic        err;

  always_comb begin
    legal   = (bus.CRY_FUNC3 == CRY_ENC) || (bus.CRY_FUNC3 == CRY_DEC);
    in_mode = (bus.CRY_FUNC3 == CRY_DEC) ? MODE_DEC : MODE_ENC;
    rx      = (state == IDLE) ? bus.CRY_RS1 : dreg;
    rr      = (state == IDLE) ? 2'd0 : rnd;
    rmode   = (state == IDLE) ? in_mode : mode;
    step_ok = bus.CRY_EN && (bus.CRY_COUNT == rnd);
    valid   = !CRY_RESET && (state == RUN) && step_ok && (rnd == 2'd3);
    // Reset masks errors so an abort never reports a spurious fault.
    if (state == IDLE)
      err = !CRY_RESET && bus.CRY_EN && ((bus.CRY_COUNT != 2'd0) || !legal);
    else
      err = !CRY_RESET && !step_ok;
  end

  otter_crypto_round #(.ROT_AMT(ROT_AMT), .RC(RC)) u_round (
    .x    (rx),
    .key  (bus.CRY_RS2),
    .r    (rr),
    .mode (rmode),
    .y    (ry)
  );

  always_ff @(posedge CRY_CLK) begin
    if (CRY_RESET) begin
      state <= IDLE;
      mode  <= MODE_ENC;
      rnd   <= 2'd0;
      dreg  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.CRY_EN && (bus.CRY_COUNT == 2'd0) && legal) begin
            mode  <= in_mode;
            dreg  <= ry;
            rnd   <= 2'd1;
            state <= RUN;
          end
        end
        RUN: begin
          if (step_ok && (rnd != 2'd3)) begin
            dreg <= ry;
            rnd  <= rnd + 2'd1;
          end else begin
            state <= IDLE;
            rnd   <= 2'd0;
          end
        end
        default: begin
          state <= IDLE;
          rnd   <= 2'd0;
        end
      endcase
    end
  end

  assign bus.CRY_VALID  = valid;
  assign bus.CRY_ERR    = err;
  assign bus.CRY_BUSY   = (state == RUN);
  assign bus.CRY_RESULT = valid ? ry : 32'd0;

endmodule

// File: tb/tb_otter_crypto_unit.sv
// Scoreboard bench for otter_crypto_unit: expected results queued at stimulus, popped on VALID.
module tb_otter_crypto_unit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;
  logic [31:0] sb[$];
  int   vcycles[$];

  otter_crypto_if bus();

  otter_crypto_unit dut (
    .CRY_CLK   (clk),
    .CRY_RESET (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model written from the algorithm description, bit-rotation by loop.
  function automatic logic [31:0] m_rotl(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) v = {v[30:0], v[31]};
    return v;
  endfunction

  function automatic logic [31:0] m_key(input logic [31:0] k, input int r);
    logic [31:0] c;
    c = 32'h9E3779B9;
    return m_rotl(k, 8 * r) ^ 32'(c * 32'(r + 1));
  endfunction

  function automatic logic [31:0] m_enc(input logic [31:0] p, input logic [31:0] k);
    logic [31:0] x;
    x = p;
    for (int r = 0; r < 4; r++) x = m_rotl(x ^ m_key(k, r), 5) + m_key(k, r);
    return x;
  endfunction

  always @(negedge clk) begin
    if (bus.CRY_VALID === 1'b1) begin
      vcycles.push_back(cyc);
      if (sb.size() == 0) check("unexp_valid", {31'd0, bus.CRY_VALID}, 32'd0);
      else check("result", bus.CRY_RESULT, sb.pop_front());
    end else if (!rst) begin
      check("gated_result", bus.CRY_RESULT, 32'd0);
    end
  end

  task automatic drive(input logic en, input logic [1:0] cnt, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic r);
    @(posedge clk);
    #1;
    rst           = r;
    bus.CRY_EN    = en;
    bus.CRY_COUNT = cnt;
    bus.CRY_FUNC3 = f3;
    bus.CRY_RS1   = a;
    bus.CRY_RS2   = b;
    @(negedge clk);
  endtask

  task automatic run_seq(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), f3, a, b, 1'b0);
      check("seq_err", {31'd0, bus.CRY_ERR}, 32'd0);
      check("seq_valid", {31'd0, bus.CRY_VALID}, (i == 3) ? 32'd1 : 32'd0);
      if (i > 0) check("seq_busy", {31'd0, bus.CRY_BUSY}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] c;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst           = 1'b1;
    bus.CRY_EN    = 1'b0;
    bus.CRY_COUNT = 2'd0;
    bus.CRY_FUNC3 = 3'b000;
    bus.CRY_RS1   = 32'd0;
    bus.CRY_RS2   = 32'd0;
    repeat (3) @(posedge clk);

    // Reset state
    drive(1'b0, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("rst_busy", {31'd0, bus.CRY_BUSY}, 32'd0);
    check("rst_valid", {31'd0, bus.CRY_VALID}, 32'd0);
    check("rst_err", {31'd0, bus.CRY_ERR}, 32'd0);
    check("rst_result", bus.CRY_RESULT, 32'd0);
    check("rst_dreg", dut.dreg, 32'd0);

    // 1: zero block, zero key
    sb.push_back(m_enc(32'd0, 32'd0));
    drive(1'b1, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("t1_valid0", {31'd0, bus.CRY_VALID}, 32'd0);
    drive(1'b1, 2'd1, 3'b000, 32'd0, 32'd0, 1'b0);
    check("t1_dreg", dut.dreg, 32'h6526B0EC);
    check("t1_busy", {31'd0, bus.CRY_BUSY}, 32'd1);
    check("t1_valid1", {31'd0, bus.CRY_VALID}, 32'd0);
    drive(1'b1, 2'd2, 3'b000, 32'd0, 32'd0, 1'b0);
    check("t1_valid2", {31'd0, bus.CRY_VALID}, 32'd0);
    drive(1'b1, 2'd3, 3'b000, 32'd0, 32'd0, 1'b0);
    check("t1_valid3", {31'd0, bus.CRY_VALID}, 32'd1);
    drive(1'b0, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("t1_idle", {31'd0, bus.CRY_BUSY}, 32'd0);

    // 2: encrypt then decrypt round-trip
    c = m_enc(32'hDEADBEEF, 32'h01234567);
    sb.push_back(c);
    run_seq(3'b000, 32'hDEADBEEF, 32'h01234567);
    drive(1'b0, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);
    sb.push_back(32'hDEADBEEF);
    run_seq(3'b001, c, 32'h01234567);
    drive(1'b0, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);

    // 3: skipped count
    drive(1'b1, 2'd0, 3'b000, 32'h12345678, 32'hA5A5A5A5, 1'b0);
    drive(1'b1, 2'd1, 3'b000, 32'h12345678, 32'hA5A5A5A5, 1'b0);
    drive(1'b1, 2'd3, 3'b000, 32'h12345678, 32'hA5A5A5A5, 1'b0);
    check("t3_err", {31'd0, bus.CRY_ERR}, 32'd1);
    check("t3_valid", {31'd0, bus.CRY_VALID}, 32'd0);
    drive(1'b0, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("t3_idle", {31'd0, bus.CRY_BUSY}, 32'd0);
    check("t3_err_clr", {31'd0, bus.CRY_ERR}, 32'd0);
    sb.push_back(m_enc(32'h12345678, 32'hA5A5A5A5));
    run_seq(3'b000, 32'h12345678, 32'hA5A5A5A5);
    drive(1'b0, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);

    // 4: reset mid-sequence
    drive(1'b1, 2'd0, 3'b000, 32'hCAFEF00D, 32'h0BADC0DE, 1'b0);
    drive(1'b1, 2'd1, 3'b000, 32'hCAFEF00D, 32'h0BADC0DE, 1'b0);
    drive(1'b1, 2'd2, 3'b000, 32'hCAFEF00D, 32'h0BADC0DE, 1'b1);
    check("t4_rst_err", {31'd0, bus.CRY_ERR}, 32'd0);
    drive(1'b1, 2'd3, 3'b000, 32'hCAFEF00D, 32'h0BADC0DE, 1'b0);
    check("t4_busy", {31'd0, bus.CRY_BUSY}, 32'd0);
    check("t4_dreg", dut.dreg, 32'd0);
    check("t4_err", {31'd0, bus.CRY_ERR}, 32'd1);
    check("t4_valid", {31'd0, bus.CRY_VALID}, 32'd0);
    drive(1'b0, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);

    // 5: back-to-back with one idle cycle, different keys
    vcycles.delete();
    sb.push_back(m_enc(32'h00C0FFEE, 32'h11111111));
    run_seq(3'b000, 32'h00C0FFEE, 32'h11111111);
    drive(1'b0, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);
    sb.push_back(m_enc(32'h00C0FFEE, 32'hCAFEBABE));
    run_seq(3'b000, 32'h00C0FFEE, 32'hCAFEBABE);
    drive(1'b0, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("t5_npulses", 32'(vcycles.size()), 32'd2);
    if (vcycles.size() == 2) check("t5_gap", 32'(vcycles[1] - vcycles[0]), 32'd5);

    // 6: illegal func3
    drive(1'b1, 2'd0, 3'b010, 32'h55AA55AA, 32'h01020304, 1'b0);
    check("t6_err", {31'd0, bus.CRY_ERR}, 32'd1);
    check("t6_result", bus.CRY_RESULT, 32'd0);
    drive(1'b0, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("t6_busy", {31'd0, bus.CRY_BUSY}, 32'd0);
    check("t6_err_clr", {31'd0, bus.CRY_ERR}, 32'd0);

    drive(1'b0, 2'd0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
